// File: rtl/fpu_pkg.sv
// Shared FPU package: IEEE-754 single-precision field widths, constants and the packed float view.
`default_nettype none

package fpu_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int FRAC_W  = 23;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int PROD_W  = 2 * MANT_W;

    localparam logic [31:0] ZERO = 32'h00000000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Biased exponent with headroom for sums, the -BIAS offset and two increments.
    typedef logic signed [9:0] exp_t;

endpackage

`default_nettype wire

// File: rtl/fmul_norm_round.sv
// Normalise (consumed in stage 2) and round/pack (consumed in stage 3) for the single-precision multiplier.
`default_nettype none

module fmul_norm_round
    import fpu_pkg::*;
(
    input  logic [PROD_W-1:0] prod_i,
    input  exp_t              e_i,
    output logic [FRAC_W-1:0] norm_frac_o,
    output logic              norm_guard_o,
    output logic              norm_sticky_o,
    output exp_t              norm_e_o,

    input  logic [FRAC_W-1:0] rnd_frac_i,
    input  logic              rnd_guard_i,
    input  logic              rnd_sticky_i,
    input  exp_t              rnd_e_i,
    input  logic              rnd_sign_i,
    input  logic              rnd_zero_i,
    output logic [31:0]       result_o
);

    always_comb begin
        if (prod_i[PROD_W-1]) begin
            norm_frac_o   = prod_i[46:24];
            norm_guard_o  = prod_i[23];
            norm_sticky_o = |prod_i[22:0];
            norm_e_o      = e_i + exp_t'(1);
        end else begin
            norm_frac_o   = prod_i[45:23];
            norm_guard_o  = prod_i[22];
            norm_sticky_o = |prod_i[21:0];
            norm_e_o      = e_i;
        end
    end

    logic          w_inc;
    logic [FRAC_W:0] w_sum;
    exp_t          w_e_final;
    fp32_t         w_pack;

    always_comb begin
        w_inc     = rnd_guard_i & (rnd_sticky_i | rnd_frac_i[0]);
        // A carry out of the fraction leaves w_sum[FRAC_W-1:0] at zero and bumps the exponent.
        w_sum     = {1'b0, rnd_frac_i} + {{FRAC_W{1'b0}}, w_inc};
        w_e_final = rnd_e_i + exp_t'({9'd0, w_sum[FRAC_W]});

        w_pack.sign = rnd_sign_i;
        w_pack.exp  = w_e_final[EXP_W-1:0];
        w_pack.frac = w_sum[FRAC_W-1:0];

        if (rnd_zero_i || (w_e_final <= exp_t'(0))) begin
            result_o = ZERO;
        end else if (w_e_final >= exp_t'(EXP_MAX)) begin
            result_o = {rnd_sign_i, 8'hFF, 23'd0};
        end else begin
            result_o = w_pack;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fmul_pipe.sv
// Three-stage pipelined single-precision multiplier: partial products, sum/normalise, round/pack.
`default_nettype none

module fmul_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result,
    output logic        out_valid
);

    // Stage 1 state
    logic              s1_q, s1_d;
    exp_t              e1_q, e1_d;
    logic              z1_q, z1_d;
    logic [35:0]       pp_lo_q, pp_lo_d;
    logic [35:0]       pp_hi_q, pp_hi_d;
    logic              v1_q;

    // Stage 2 state
    logic              s2_q;
    exp_t              e2_q, e2_d;
    logic              z2_q;
    logic [FRAC_W-1:0] frac2_q, frac2_d;
    logic              guard2_q, guard2_d;
    logic              sticky2_q, sticky2_d;
    logic              v2_q;

    // Stage 3 state
    logic [31:0]       result_q, result_d;
    logic              out_valid_q;

    fp32_t             w_a, w_b;
    logic [MANT_W-1:0] w_ma, w_mb;
    logic [PROD_W-1:0] w_prod;

    always_comb begin
        w_a     = op1;
        w_b     = op2;
        w_ma    = {1'b1, w_a.frac};
        w_mb    = {1'b1, w_b.frac};
        s1_d    = w_a.sign ^ w_b.sign;
        e1_d    = exp_t'({2'b00, w_a.exp}) + exp_t'({2'b00, w_b.exp}) - exp_t'(BIAS);
        z1_d    = (w_a.exp == '0) || (w_b.exp == '0);
        pp_lo_d = 36'(w_ma) * 36'(w_mb[11:0]);
        pp_hi_d = 36'(w_ma) * 36'(w_mb[23:12]);
        w_prod  = {12'd0, pp_lo_q} + {pp_hi_q, 12'd0};
    end

    fmul_norm_round u_norm_round (
        .prod_i        (w_prod),
        .e_i           (e1_q),
        .norm_frac_o   (frac2_d),
        .norm_guard_o  (guard2_d),
        .norm_sticky_o (sticky2_d),
        .norm_e_o      (e2_d),
        .rnd_frac_i    (frac2_q),
        .rnd_guard_i   (guard2_q),
        .rnd_sticky_i  (sticky2_q),
        .rnd_e_i       (e2_q),
        .rnd_sign_i    (s2_q),
        .rnd_zero_i    (z2_q),
        .result_o      (result_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q        <= 1'b0;
            e1_q        <= '0;
            z1_q        <= 1'b0;
            pp_lo_q     <= '0;
            pp_hi_q     <= '0;
            v1_q        <= 1'b0;
            s2_q        <= 1'b0;
            e2_q        <= '0;
            z2_q        <= 1'b0;
            frac2_q     <= '0;
            guard2_q    <= 1'b0;
            sticky2_q   <= 1'b0;
            v2_q        <= 1'b0;
            result_q    <= ZERO;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s1_q        <= s1_d;
            e1_q        <= e1_d;
            z1_q        <= z1_d;
            pp_lo_q     <= pp_lo_d;
            pp_hi_q     <= pp_hi_d;
            v1_q        <= in_valid;
            s2_q        <= s1_q;
            e2_q        <= e2_d;
            z2_q        <= z1_q;
            frac2_q     <= frac2_d;
            guard2_q    <= guard2_d;
            sticky2_q   <= sticky2_d;
            v2_q        <= v1_q;
            result_q    <= result_d;
            out_valid_q <= v2_q;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fmul_pipe.sv
// Directed-vector bench for fmul_pipe: per-vector latency checks, a stalled/bubbled stream and mid-flight reset.
`default_nettype none

module tb_fmul_pipe;

    logic        clk;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] result;
    logic        out_valid;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    // Expected contents of the three pipeline stages (index 3 is the output register).
    logic        mv [1:3];
    logic [31:0] mr [1:3];

    fmul_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .op1       (op1),
        .op2       (op2),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the expected pipeline, compare outputs.
    task automatic step(input string tag, input logic rst_n, input logic en_v, input logic vld,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] expd);
        reset    = rst_n;
        en       = en_v;
        in_valid = vld;
        op1      = a;
        op2      = b;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 1; i <= 3; i++) begin
                mv[i] = 1'b0;
                mr[i] = 32'h0;
            end
        end else if (en_v) begin
            mv[3] = mv[2]; mr[3] = mr[2];
            mv[2] = mv[1]; mr[2] = mr[1];
            mv[1] = vld;   mr[1] = expd;
        end
        check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, mv[3]});
        if (mv[3] || !rst_n)
            check({tag, " result"}, result, mr[3]);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        op1      = 32'h0;
        op2      = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            mv[i] = 1'b0;
            mr[i] = 32'h0;
        end

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000};  // 1.5 * 2
        vecs[1]  = '{32'hC0000000, 32'h3FC00000, 32'hC0400000};  // -2 * 1.5
        vecs[2]  = '{32'h00000000, 32'h40490FDB, 32'h00000000};  // zero operand
        vecs[3]  = '{32'h00800000, 32'h3F000000, 32'h00000000};  // underflow to e=0
        vecs[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000};  // overflow
        vecs[5]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002};  // rounding
        vecs[6]  = '{32'hC0000000, 32'hC0000000, 32'h40800000};  // -2 * -2
        vecs[7]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};  // 1.5^2, p[47] set
        vecs[8]  = '{32'h3FFFF800, 32'h3F800400, 32'h40000000};  // round carry out of frac
        vecs[9]  = '{32'h7F7FF800, 32'h3F800400, 32'h7F800000};  // rounding pushes to overflow
        vecs[10] = '{32'h80000000, 32'hC0000000, 32'h00000000};  // -0 gives +0
        vecs[11] = '{32'h00400000, 32'h40000000, 32'h00000000};  // subnormal flushes
        vecs[12] = '{32'h00800000, 32'h00800000, 32'h00000000};  // deep underflow
        vecs[13] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};  // near-2 squared

        step("reset0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        step("reset1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d issue", i), 1'b1, 1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
            for (int j = 0; j < 3; j++)
                step($sformatf("vec%0d wait%0d", i, j), 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        end

        // Stream with a 2-cycle stall (live inputs must be ignored) and one bubble.
        step("stream0", 1'b1, 1'b1, 1'b1, vecs[0].a, vecs[0].b, vecs[0].exp);
        step("stream1", 1'b1, 1'b1, 1'b1, vecs[1].a, vecs[1].b, vecs[1].exp);
        step("stall0",  1'b1, 1'b0, 1'b1, vecs[4].a, vecs[4].b, vecs[4].exp);
        step("stall1",  1'b1, 1'b0, 1'b1, vecs[4].a, vecs[4].b, vecs[4].exp);
        step("stream2", 1'b1, 1'b1, 1'b1, vecs[5].a, vecs[5].b, vecs[5].exp);
        step("bubble",  1'b1, 1'b1, 1'b0, vecs[4].a, vecs[4].b, vecs[4].exp);
        step("stream3", 1'b1, 1'b1, 1'b1, vecs[6].a, vecs[6].b, vecs[6].exp);
        step("stream4", 1'b1, 1'b1, 1'b1, vecs[7].a, vecs[7].b, vecs[7].exp);
        step("stall2",  1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step("stream5", 1'b1, 1'b1, 1'b1, vecs[8].a, vecs[8].b, vecs[8].exp);
        for (int j = 0; j < 4; j++)
            step($sformatf("drain%0d", j), 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

        // Reset with three requests in flight, taken while en is low.
        step("fly0", 1'b1, 1'b1, 1'b1, vecs[0].a, vecs[0].b, vecs[0].exp);
        step("fly1", 1'b1, 1'b1, 1'b1, vecs[4].a, vecs[4].b, vecs[4].exp);
        step("fly2", 1'b1, 1'b1, 1'b1, vecs[7].a, vecs[7].b, vecs[7].exp);
        step("midreset", 1'b0, 1'b0, 1'b1, vecs[1].a, vecs[1].b, vecs[1].exp);
        check("midreset result zero", result, 32'h0);
        for (int j = 0; j < 5; j++)
            step($sformatf("postreset%0d", j), 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fmul_pipe.md
# fmul_pipe

Pipelined single-precision floating-point multiplier, the multiplicative counterpart of the FPU's pipelined divider. It accepts one operand pair per enabled cycle and returns the product after a fixed 3-cycle latency. A valid bit travels alongside the data. Subnormals flush to zero and underflow returns zero, matching the divider. It sits in the FPU execute stage beside the divider and shares the result mux.

## Interface
- Parameters: none. Latency is fixed at 3.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- en  in  1  pipeline advance; low = every register holds
- in_valid  in  1  op1/op2 carry a request this cycle
- op1  in  32  IEEE-754 single multiplicand
- op2  in  32  IEEE-754 single multiplier
- result  out  32  product, registered
- out_valid  out  1  result holds the product of a request issued 3 enabled cycles earlier

## Operation
- Unpack:
  - sign s = op1[31]^op2[31]
  - mantissas ma/mb = {1, frac}, 24 bits
  - exponent sum e = exp1 + exp2 − 127, 10-bit signed
- Zero rule: either exponent == 0 → result 32'h00000000 (positive zero) regardless of sign or fraction.
- Product: p = ma*mb, 48 bits.
- Normalise:
  - p[47]=1 → frac = p[46:24], guard = p[23], sticky = |p[22:0], e = e+1
  - else → frac = p[45:23], guard = p[22], sticky = |p[21:0]
- Round to nearest-even: increment when guard & (sticky | frac[0]).
  - A carry out of frac gives frac = 0 and e = e+1.
- Overflow: final e ≥ 255 → {s, 8'hFF, 23'd0}.
- Underflow: final e ≤ 0 → 32'h00000000.
- Otherwise result = {s, e[7:0], frac}.
- Inputs with exponent 255 are processed as ordinary numbers. That output is unspecified and not checked.

## Timing
- Stage 1 (register):
  - s, e, zero flag
  - partial products ma*mb[11:0] and ma*mb[23:12], each 36 bits
  - v1 = in_valid
- Stage 2 (register):
  - summed 48-bit product, normalised frac/guard/sticky, adjusted e, s, zero flag
  - v2 = v1
- Stage 3 (register): rounded and packed result; out_valid = v2.
- Request sampled at enabled edge k → result/out_valid valid after enabled edge k+3. Throughput is one per enabled cycle.
- en low: all stage registers, result and out_valid hold. Consumer qualifies with en.
- in_valid low on an enabled edge inserts a bubble; out_valid falls 3 enabled edges later.
- Reset (reset=0 at a clock edge): result=0, out_valid=0, v1=v2=0, all data stage registers=0. Reset has priority over en. In-flight requests are discarded and nothing is emitted afterwards for them.
- result is don't-care while out_valid=0, but is reset to 0.

## Structure
- Shared package fpu_pkg, also used by the divider:
  - BIAS=127
  - EXP_MAX=255
  - field widths FRAC_W=23 and EXP_W=8
  - ZERO=32'h00000000
  - a packed struct for {sign, exp, frac}
- One combinational sub-module, fmul_norm_round:
  - inputs: 48-bit product, e, s, zero flag
  - output: packed 32-bit result
  - normalise sits in stage 2 and round/pack in stage 3, so it exposes both halves separately.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2) with in_valid=1, en=1 → result 0x40400000 with out_valid=1 exactly 3 cycles later. out_valid=0 in between.
- 0xC0000000 × 0x3FC00000 → 0xC0400000.
- 0x00000000 × 0x40490FDB → 0x00000000.
- 0x00800000 × 0x3F000000 (underflow) → 0x00000000.
- 0x7F000000 × 0x40000000 → 0x7F800000.
- 0x3F800001 × 0x3F800001 (rounding) → 0x3F800002.
- Back-to-back stream of 6 requests with en dropped for 2 cycles mid-stream and one in_valid=0 bubble → outputs in order, held during en=0, one out_valid gap.
- reset asserted while 3 requests are in flight → out_valid=0 and result=0 on the next edge, and no stale outputs appear afterwards.
